// File: rtl/sprite_pkg.sv
// Shared types, register map offsets and the RGB565->RGB888 expansion for the sprite compositor.
package sprite_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam logic [8:0] FLD_X    = 9'd0;
    localparam logic [8:0] FLD_Y    = 9'd1;
    localparam logic [8:0] FLD_CTRL = 9'd2;
    localparam logic [8:0] BG_ADDR  = 9'h1F0;
    localparam int         CTRL_EN    = 0;
    localparam int         CTRL_HFLIP = 1;

    function automatic rgb888_t rgb565_to_888(input rgb565_t p);
        rgb888_t o;
        o.r = {p.r, p.r[4:2]};
        o.g = {p.g, p.g[5:4]};
        o.b = {p.b, p.b[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// One sprite's hit test and ROM address for the current raster position (combinational).
// Mirroring is compiled in only with SPRITE_COMPOSITOR_HFLIP_EN.
module sprite_hit_unit #(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter int AW    = $clog2(SPR_W * SPR_H)
) (
    input  logic [10:0]   hcount,
    input  logic [9:0]    vcount,
    input  logic [10:0]   x,
    input  logic [9:0]    y,
    input  logic          en,
    input  logic          hflip,
    output logic          hit,
    output logic [AW-1:0] addr
);
    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);

    logic [11:0]   hc12, vc12, x12, y12;
    logic [CW-1:0] col_raw, col;
    logic [RW-1:0] row;

    // 12-bit compares so a sprite near x=2047 cannot wrap onto column 0
    assign hc12 = {1'b0, hcount};
    assign vc12 = {2'b0, vcount};
    assign x12  = {1'b0, x};
    assign y12  = {2'b0, y};

    assign hit = en && (hc12 >= x12) && (hc12 < x12 + 12'(SPR_W))
                    && (vc12 >= y12) && (vc12 < y12 + 12'(SPR_H));

    assign col_raw = hcount[CW-1:0] - x[CW-1:0];
    assign row     = vcount[RW-1:0] - y[RW-1:0];

`ifdef SPRITE_COMPOSITOR_HFLIP_EN
    assign col = hflip ? ~col_raw : col_raw;
`else
    logic unused_hflip;
    assign unused_hflip = hflip;
    assign col = col_raw;
`endif

    assign addr = {row, col};

endmodule

// File: rtl/sprite_compositor.sv
// Double-buffered sprite registers and a 2-clock hit/fetch/priority pipeline onto VGA.
// Optional macro: SPRITE_COMPOSITOR_HFLIP_EN enables ctrl bit1 horizontal mirroring.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter logic [15:0] TRANSP_KEY  = 16'hF81F,
    parameter int          HACTIVE     = 1280,
    parameter int          VACTIVE     = 480,
    parameter int          AW          = $clog2(SPR_W * SPR_H)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      chipselect,
    input  logic                      write,
    input  logic [31:0]               writedata,
    input  logic [8:0]                address,
    input  logic [10:0]               hcount,
    input  logic [9:0]                vcount,
    input  logic                      blank_n_in,
    input  logic                      hs_in,
    input  logic                      vs_in,
    output logic [NUM_SPRITES*AW-1:0] spr_addr,
    input  logic [NUM_SPRITES*16-1:0] spr_data,
    output logic [7:0]                VGA_R,
    output logic [7:0]                VGA_G,
    output logic [7:0]                VGA_B,
    output logic                      VGA_BLANK_n,
    output logic                      VGA_HS,
    output logic                      VGA_VS,
    output logic                      commit_pulse
);
    logic [NUM_SPRITES-1:0][10:0] sh_x, act_x;
    logic [NUM_SPRITES-1:0][9:0]  sh_y, act_y;
    logic [NUM_SPRITES-1:0][1:0]  sh_ctrl, act_ctrl;
    logic [23:0]                  sh_bg, act_bg;

    logic [NUM_SPRITES-1:0]         hit_c, hit_s1;
    logic [NUM_SPRITES-1:0][AW-1:0] addr_c;
    logic [1:0]                     blank_pipe, hs_pipe, vs_pipe;
    logic                           wr_en, commit;
    rgb888_t                        sel;

    logic unused_cfg;
    assign unused_cfg = &{1'b0, writedata[31:24], 11'(HACTIVE)};

    assign wr_en        = chipselect && write;
    assign commit       = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
    assign commit_pulse = commit && !reset;

    // Shadow takes bus writes; active copies the pre-write shadow at commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_x <= '0; sh_y <= '0; sh_ctrl <= '0; sh_bg <= '0;
            act_x <= '0; act_y <= '0; act_ctrl <= '0; act_bg <= '0;
        end else begin
            if (wr_en) begin
                if (address == BG_ADDR) sh_bg <= writedata[23:0];
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (address == 9'(4 * i) + FLD_X)    sh_x[i]    <= writedata[10:0];
                    if (address == 9'(4 * i) + FLD_Y)    sh_y[i]    <= writedata[9:0];
                    if (address == 9'(4 * i) + FLD_CTRL) sh_ctrl[i] <= writedata[1:0];
                end
            end
            if (commit) begin
                act_x <= sh_x; act_y <= sh_y; act_ctrl <= sh_ctrl; act_bg <= sh_bg;
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit_unit #(.SPR_W(SPR_W), .SPR_H(SPR_H), .AW(AW)) u_hit (
            .hcount(hcount),
            .vcount(vcount),
            .x     (act_x[g]),
            .y     (act_y[g]),
            .en    (act_ctrl[g][CTRL_EN]),
            .hflip (act_ctrl[g][CTRL_HFLIP]),
            .hit   (hit_c[g]),
            .addr  (addr_c[g])
        );
    end

    // Stage 0 -> 1: ROM address and hit flags; sync signals ride alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spr_addr   <= '0;
            hit_s1     <= '0;
            blank_pipe <= '0;
            hs_pipe    <= '1;
            vs_pipe    <= '1;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) spr_addr[i*AW +: AW] <= addr_c[i];
            hit_s1     <= hit_c;
            blank_pipe <= {blank_pipe[0], blank_n_in};
            hs_pipe    <= {hs_pipe[0], hs_in};
            vs_pipe    <= {vs_pipe[0], vs_in};
        end
    end

    assign VGA_BLANK_n = blank_pipe[1];
    assign VGA_HS      = hs_pipe[1];
    assign VGA_VS      = vs_pipe[1];

    // Walk from the top index down so the lowest opaque index wins.
    always_comb begin
        sel = rgb888_t'(act_bg);
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_s1[i] && (spr_data[i*16 +: 16] != TRANSP_KEY))
                sel = rgb565_to_888(rgb565_t'(spr_data[i*16 +: 16]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            VGA_R <= '0; VGA_G <= '0; VGA_B <= '0;
        end else if (blank_pipe[0]) begin
            VGA_R <= sel.r; VGA_G <= sel.g; VGA_B <= sel.b;
        end else begin
            VGA_R <= '0; VGA_G <= '0; VGA_B <= '0;
        end
    end

endmodule
